// File: rtl/tile_packer_if.sv
// Stream-in / tile-out bus of the tile packer: element handshake plus the flattened SRAM tile write port.
interface tile_packer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int M          = 4,
  parameter int N          = 4
);
  logic                         in_valid;
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         in_ready;
  logic                         sram_we;
  logic [ADDR_WIDTH-1:0]        sram_addr;
  logic [M*N*DATA_WIDTH-1:0]    sram_data;

  modport master (output in_valid, in_data, input in_ready, sram_we, sram_addr, sram_data);
  modport slave  (input in_valid, in_data, output in_ready, sram_we, sram_addr, sram_data);
endinterface

// File: rtl/tile_packer.sv
// Packs a row-major element stream into MxN tiles; each full tile is issued as one SRAM write.
module tile_packer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_tiles,
  tile_packer_if.slave          bus,
  output logic                  busy,
  output logic                  done
);
  localparam int TILE = M * N;
  localparam int EW   = (TILE > 1) ? $clog2(TILE) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      base_q, addr_q;
  logic [CNT_WIDTH-1:0]       num_q, tile_idx_q;
  logic [EW-1:0]              elem_idx_q;
  logic [TILE*DATA_WIDTH-1:0] data_q;
  logic                       done_q;
  logic                       launch, accept, last_elem, last_tile;

  assign launch    = (state_q == IDLE) && start && (num_tiles != '0);
  assign accept    = (state_q == FILL) && bus.in_valid;
  assign last_elem = elem_idx_q == EW'(TILE - 1);
  assign last_tile = tile_idx_q == (num_q - CNT_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = FILL;
      FILL:    if (accept && last_elem) state_d = WRITE;
      WRITE:   state_d = last_tile ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      addr_q     <= '0;
      tile_idx_q <= '0;
      elem_idx_q <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // A zero-count start completes immediately without touching any captured state.
      done_q  <= ((state_q == IDLE) && start && (num_tiles == '0)) ||
                 ((state_q == WRITE) && last_tile);
      if (launch) begin
        base_q     <= base_addr;
        num_q      <= num_tiles;
        tile_idx_q <= '0;
        elem_idx_q <= '0;
      end
      if (accept) begin
        data_q[elem_idx_q*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
        elem_idx_q <= last_elem ? '0 : elem_idx_q + EW'(1);
        // Address is computed as the tile completes so it is ready in the WRITE cycle.
        if (last_elem) addr_q <= base_q + ADDR_WIDTH'(32'(tile_idx_q) * TILE);
      end
      if ((state_q == WRITE) && !last_tile) tile_idx_q <= tile_idx_q + CNT_WIDTH'(1);
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.sram_we   = (state_q == WRITE);
  assign bus.sram_addr = addr_q;
  assign bus.sram_data = data_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
endmodule

// File: tb/tb_tile_packer.sv
// Scoreboard bench for tile_packer: expected tiles are queued as elements are handed over, observed writes are queued by a monitor.
module tb_tile_packer;
  localparam int AW = 16, DW = 8, M = 4, N = 4, CW = 8, T = M * N;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_tiles = '0;
  logic          busy, done;

  tile_packer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .M(M), .N(N)) bif ();

  tile_packer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .M(M), .N(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_tiles(num_tiles),
    .bus(bif.slave), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic rdy; logic [AW-1:0] addr; logic [T*DW-1:0] data; } obs_t;
  typedef struct { logic [AW-1:0] addr; logic [T*DW-1:0] data; } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int cyc = 0, done_cnt = 0, done_cyc = -1, hs = 0;
  int pass = 0, total = 0;
  logic [DW-1:0] val = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bif.in_valid && bif.in_ready) hs <= hs + 1;
  end

  always @(negedge clk) begin
    if (bif.sram_we) obs_q.push_back('{cyc, bif.in_ready, bif.sram_addr, bif.sram_data});
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  // mode 0: back-to-back, 1: in_valid toggles, 2: in_valid held high from start through done
  task automatic run_job(input logic [AW-1:0] b, input logic [CW-1:0] n, input int mode,
                         input bit ign, input int stop_after, output int c);
    logic [T*DW-1:0] tile = '0;
    int acc = 0, budget, d0 = done_cnt;
    bit tog = 1'b0, v;
    @(negedge clk);
    start = 1'b1; base_addr = b; num_tiles = n; c = cyc;
    bif.in_valid = (mode == 2); bif.in_data = val; val++;
    budget = int'(n) * T * 3 + 50;
    while (acc < int'(n) * T && acc != stop_after && budget > 0) begin
      @(negedge clk); budget--;
      start = 1'b0;
      if (ign && acc == 5) begin start = 1'b1; base_addr = 16'h5555; num_tiles = 8'd5; end
      v = (mode == 1) ? tog : 1'b1; tog = !tog;
      bif.in_valid = v; bif.in_data = val;
      if (v && bif.in_ready) begin
        tile[(acc % T)*DW +: DW] = val; acc++;
        if (acc % T == 0) exp_q.push_back('{b + AW'((acc / T - 1) * T), tile});
      end
      val++;
    end
    if (budget == 0) begin total++; $display("FAIL feed_timeout: accepted %0d of %0d", acc, int'(n) * T); end
    if (acc == stop_after) return;
    budget = 100;
    while (done_cnt == d0 && budget > 0) begin
      @(negedge clk); budget--; start = 1'b0;
      if (mode == 2) begin bif.in_valid = 1'b1; bif.in_data = val; val++; end
      else bif.in_valid = 1'b0;
    end
    if (budget == 0) begin total++; $display("FAIL done_timeout: done never pulsed, base %h", b); end
    @(negedge clk); bif.in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({busy, done, bif.in_ready, bif.sram_we} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {busy, done, bif.in_ready, bif.sram_we}); else pass++;
    total++; if (bif.sram_addr !== '0) $display("FAIL reset_addr: got %h want 0", bif.sram_addr); else pass++;
    total++; if (bif.sram_data !== '0) $display("FAIL reset_data: got %h want 0", bif.sram_data); else pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int c, d0;
    obs_q.delete(); exp_q.delete(); d0 = done_cnt; val = 8'h00;
    run_job(16'h0100, 8'd1, 0, 1'b0, -1, c);
    repeat (3) @(negedge clk);
    total++; if (obs_q.size() !== 1) $display("FAIL single_count: got %0d writes want 1", obs_q.size()); else pass++;
    if (obs_q.size() >= 1) begin
      total++; if (obs_q[0].cyc !== c + 17) $display("FAIL single_latency: write at %0d want %0d", obs_q[0].cyc - c, 17); else pass++;
      total++; if (obs_q[0].addr !== 16'h0100) $display("FAIL single_addr: got %h want 0100", obs_q[0].addr); else pass++;
      total++; if (obs_q[0].data[7:0] !== 8'h01 || obs_q[0].data[127:120] !== 8'h10)
        $display("FAIL single_corners: got (0,0)=%h (3,3)=%h want 01 10", obs_q[0].data[7:0], obs_q[0].data[127:120]); else pass++;
      total++; if (obs_q[0].data !== exp_q[0].data) $display("FAIL single_data: got %h want %h", obs_q[0].data, exp_q[0].data); else pass++;
    end
    total++; if (done_cyc !== c + 18) $display("FAIL single_done_cycle: got %0d want %0d", done_cyc - c, 18); else pass++;
    total++; if (done_cnt - d0 !== 1) $display("FAIL single_done_pulses: got %0d want 1", done_cnt - d0); else pass++;
  endtask

  task automatic test_multi_stall();
    int c, d0;
    obs_q.delete(); exp_q.delete(); d0 = done_cnt;
    run_job(16'h0200, 8'd3, 1, 1'b0, -1, c);
    repeat (3) @(negedge clk);
    total++; if (obs_q.size() !== 3) $display("FAIL multi_count: got %0d want 3", obs_q.size()); else pass++;
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      total++; if (obs_q[i].addr !== exp_q[i].addr) $display("FAIL multi_addr%0d: got %h want %h", i, obs_q[i].addr, exp_q[i].addr); else pass++;
      total++; if (obs_q[i].data !== exp_q[i].data) $display("FAIL multi_data%0d: got %h want %h", i, obs_q[i].data, exp_q[i].data); else pass++;
      total++; if (obs_q[i].rdy !== 1'b0) $display("FAIL multi_ready_in_write%0d: got %b want 0", i, obs_q[i].rdy); else pass++;
    end
    total++; if (done_cnt - d0 !== 1) $display("FAIL multi_done_pulses: got %0d want 1", done_cnt - d0); else pass++;
  endtask

  task automatic test_wrap();
    int c;
    obs_q.delete(); exp_q.delete();
    run_job(16'hFFF0, 8'd2, 0, 1'b0, -1, c);
    repeat (3) @(negedge clk);
    total++; if (obs_q.size() !== 2) $display("FAIL wrap_count: got %0d want 2", obs_q.size()); else pass++;
    if (obs_q.size() == 2) begin
      total++; if (obs_q[0].addr !== 16'hFFF0) $display("FAIL wrap_addr0: got %h want fff0", obs_q[0].addr); else pass++;
      total++; if (obs_q[1].addr !== 16'h0000) $display("FAIL wrap_addr1: got %h want 0000", obs_q[1].addr); else pass++;
      total++; if (obs_q[1].data !== exp_q[1].data) $display("FAIL wrap_data1: got %h want %h", obs_q[1].data, exp_q[1].data); else pass++;
    end
  endtask

  task automatic test_zero_and_ignored();
    int c, d0;
    obs_q.delete(); exp_q.delete();
    @(negedge clk); start = 1'b1; num_tiles = 8'd0; base_addr = 16'h1234;
    @(negedge clk); start = 1'b0;
    total++; if ({done, busy} !== 2'b10) $display("FAIL zero_done: got done,busy=%b want 10", {done, busy}); else pass++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b want 0", done); else pass++;
    repeat (3) @(negedge clk);
    total++; if (obs_q.size() !== 0) $display("FAIL zero_no_write: got %0d writes want 0", obs_q.size()); else pass++;
    d0 = done_cnt;
    run_job(16'h0600, 8'd2, 0, 1'b1, -1, c);
    repeat (3) @(negedge clk);
    total++; if (obs_q.size() !== 2) $display("FAIL ignored_count: got %0d want 2", obs_q.size()); else pass++;
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      total++; if (obs_q[i].addr !== exp_q[i].addr) $display("FAIL ignored_addr%0d: got %h want %h", i, obs_q[i].addr, exp_q[i].addr); else pass++;
    end
    total++; if (done_cnt - d0 !== 1) $display("FAIL ignored_done_pulses: got %0d want 1", done_cnt - d0); else pass++;
  endtask

  task automatic test_reset_mid();
    int c;
    obs_q.delete(); exp_q.delete();
    run_job(16'h0300, 8'd1, 0, 1'b0, 7, c);
    @(negedge clk); reset = 1'b1; bif.in_valid = 1'b0; start = 1'b0;
    @(negedge clk); reset = 1'b0;
    total++; if ({busy, done, bif.in_ready, bif.sram_we} !== 4'b0) $display("FAIL midreset_ctrl: got %b want 0000", {busy, done, bif.in_ready, bif.sram_we}); else pass++;
    total++; if (bif.sram_addr !== '0 || bif.sram_data !== '0) $display("FAIL midreset_bus: got addr %h data %h want 0", bif.sram_addr, bif.sram_data); else pass++;
    repeat (4) @(negedge clk);
    total++; if (obs_q.size() !== 0) $display("FAIL midreset_no_write: got %0d writes want 0", obs_q.size()); else pass++;
    run_job(16'h0400, 8'd1, 0, 1'b0, -1, c);
    repeat (3) @(negedge clk);
    total++; if (obs_q.size() !== 1) $display("FAIL midreset_fresh_count: got %0d want 1", obs_q.size()); else pass++;
    if (obs_q.size() == 1) begin
      total++; if (obs_q[0].addr !== 16'h0400) $display("FAIL midreset_fresh_addr: got %h want 0400", obs_q[0].addr); else pass++;
      total++; if (obs_q[0].data !== exp_q[0].data) $display("FAIL midreset_fresh_data: got %h want %h", obs_q[0].data, exp_q[0].data); else pass++;
    end
  endtask

  task automatic test_back_to_back();
    int c, h0;
    obs_q.delete(); exp_q.delete(); h0 = hs;
    run_job(16'h0700, 8'd2, 2, 1'b0, -1, c);
    repeat (3) @(negedge clk);
    total++; if (hs - h0 !== 2 * T) $display("FAIL bp_handshakes: got %0d want %0d", hs - h0, 2 * T); else pass++;
    total++; if (obs_q.size() !== 2) $display("FAIL bp_count: got %0d want 2", obs_q.size()); else pass++;
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      total++; if (obs_q[i].data !== exp_q[i].data) $display("FAIL bp_data%0d: got %h want %h", i, obs_q[i].data, exp_q[i].data); else pass++;
    end
  endtask

  initial begin
    bif.in_valid = 1'b0; bif.in_data = '0;
    test_reset();
    test_single();
    test_multi_stall();
    test_wrap();
    test_zero_and_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
